// File: rtl/mms_pkg.sv
`default_nettype none
//==============================================================================
// Module : mms_pkg
// Desc   : Shared MMU widths, Sv32 PTE bit positions, ITLB refill state enum.
// Rev    : 1.0  initial release
//==============================================================================

`ifndef MMS_PKG_DEFINES
`define MMS_PKG_DEFINES
`define ASID_WD 9
`define VPN1_WD 10
`define VPN0_WD 10
`define D_FLIP_FLOP(q, d, rst_val, clk, rstn) \
    always_ff @(posedge clk or negedge rstn) begin \
        if (!rstn) q <= (rst_val); \
        else       q <= (d); \
    end
`endif

package mms_pkg;

    localparam int ASID_W = `ASID_WD;
    localparam int VPN_W  = `VPN1_WD + `VPN0_WD;

    typedef logic [VPN_W-1:0] vpn_t;

    // Sv32 leaf PTE flag positions
    localparam int PTE_V = 0;
    localparam int PTE_R = 1;
    localparam int PTE_W = 2;
    localparam int PTE_X = 3;
    localparam int PTE_G = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DRAIN = 3'd4
    } itlb_refill_state_e;

    // An instruction page must be valid, executable and not write-only
    function automatic logic pte_fault(input logic [31:0] pte, input logic err);
        return err | ~pte[PTE_V] | ~pte[PTE_X] | (pte[PTE_W] & ~pte[PTE_R]);
    endfunction

endpackage

`default_nettype wire

// File: rtl/itlb_victim_sel.sv
`default_nettype none
//==============================================================================
// Module : itlb_victim_sel
// Desc   : ITLB victim choice: lowest invalid entry, else round-robin pointer.
// Rev    : 1.0  initial release
//==============================================================================

module itlb_victim_sel
    import mms_pkg::*;
#(
    parameter int ENTRY_NUM = 8
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [ENTRY_NUM-1:0] entry_valid_i,
    input  logic                 commit_i,
    output logic [ENTRY_NUM-1:0] victim_oh_o
);

    localparam int IDX_W = $clog2(ENTRY_NUM);

    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] w_rr_ptr_nxt;
    logic [IDX_W-1:0] w_free_idx;
    logic [IDX_W-1:0] w_victim_idx;
    logic             w_has_free;

    always_comb begin
        w_free_idx = '0;
        w_has_free = 1'b0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (!entry_valid_i[i]) begin
                w_free_idx = IDX_W'(i);
                w_has_free = 1'b1;
            end
        end
    end

    assign w_victim_idx = w_has_free ? w_free_idx : r_rr_ptr;
    assign victim_oh_o  = ENTRY_NUM'(1) << w_victim_idx;

    // ENTRY_NUM is a power of two, so natural overflow is the modulo wrap
    assign w_rr_ptr_nxt = (commit_i && !w_has_free) ? r_rr_ptr + IDX_W'(1) : r_rr_ptr;

    `D_FLIP_FLOP(r_rr_ptr, w_rr_ptr_nxt, '0, clk_i, rstn_i)

endmodule

`default_nettype wire

// File: rtl/itlb_refill_ctrl.sv
`default_nettype none
//==============================================================================
// Module : itlb_refill_ctrl
// Desc   : ITLB miss refill sequencer: PTW request/response, flush drain, write.
// Rev    : 1.0  initial release
//==============================================================================

module itlb_refill_ctrl
    import mms_pkg::*;
#(
    parameter int ENTRY_NUM = 8
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 tlb_flush_i,
    input  logic                 miss_i,
    input  logic [`ASID_WD-1:0]  miss_asid_i,
    input  vpn_t                 miss_vpn_i,
    input  logic [ENTRY_NUM-1:0] entry_valid_i,
    output logic                 ptw_req_valid_o,
    input  logic                 ptw_req_ready_i,
    output logic [`ASID_WD-1:0]  ptw_req_asid_o,
    output vpn_t                 ptw_req_vpn_o,
    input  logic                 ptw_resp_valid_i,
    input  logic [31:0]          ptw_resp_pte_i,
    input  logic                 ptw_resp_err_i,
    output logic [ENTRY_NUM-1:0] entry_we_o,
    output logic [`ASID_WD-1:0]  entry_asid_o,
    output vpn_t                 entry_vpn_o,
    output logic [31:0]          entry_pte_o,
    output logic                 entry_g_o,
    output logic                 busy_o,
    output logic                 refill_done_o,
    output logic                 refill_fault_o
);

    itlb_refill_state_e  r_state,      w_state_nxt;
    logic                r_flush_pend, w_flush_pend_nxt;
    logic [`ASID_WD-1:0] r_asid,       w_asid_nxt;
    vpn_t                r_vpn,        w_vpn_nxt;
    logic [31:0]         r_pte,        w_pte_nxt;
    logic                r_err,        w_err_nxt;
    logic                r_req_valid,  w_req_valid_nxt;
    logic                r_busy,       w_busy_nxt;

    logic                 w_in_write;
    logic                 w_fault;
    logic                 w_commit;
    logic [ENTRY_NUM-1:0] w_victim_oh;

    always_comb begin
        w_state_nxt      = r_state;
        w_flush_pend_nxt = r_flush_pend;
        w_asid_nxt       = r_asid;
        w_vpn_nxt        = r_vpn;
        w_pte_nxt        = r_pte;
        w_err_nxt        = r_err;
        case (r_state)
            ST_IDLE: begin
                if (miss_i) begin
                    w_asid_nxt       = miss_asid_i;
                    w_vpn_nxt        = miss_vpn_i;
                    w_flush_pend_nxt = 1'b0;
                    w_state_nxt      = ST_REQ;
                end
            end
            ST_REQ: begin
                // The request stays up until accepted; a flush only marks it stale
                if (r_req_valid && ptw_req_ready_i) begin
                    w_state_nxt      = (r_flush_pend || tlb_flush_i) ? ST_DRAIN : ST_WAIT;
                    w_flush_pend_nxt = 1'b0;
                end else if (tlb_flush_i) begin
                    w_flush_pend_nxt = 1'b1;
                end
            end
            ST_WAIT: begin
                if (tlb_flush_i) begin
                    w_state_nxt = ptw_resp_valid_i ? ST_IDLE : ST_DRAIN;
                end else if (ptw_resp_valid_i) begin
                    w_pte_nxt   = ptw_resp_pte_i;
                    w_err_nxt   = ptw_resp_err_i;
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_DRAIN: begin
                if (ptw_resp_valid_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WRITE: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_req_valid_nxt = (w_state_nxt == ST_REQ);
    assign w_busy_nxt      = (w_state_nxt != ST_IDLE);

    `D_FLIP_FLOP(r_state,      w_state_nxt,      ST_IDLE, clk_i, rstn_i)
    `D_FLIP_FLOP(r_flush_pend, w_flush_pend_nxt, 1'b0,    clk_i, rstn_i)
    `D_FLIP_FLOP(r_asid,       w_asid_nxt,       '0,      clk_i, rstn_i)
    `D_FLIP_FLOP(r_vpn,        w_vpn_nxt,        '0,      clk_i, rstn_i)
    `D_FLIP_FLOP(r_pte,        w_pte_nxt,        '0,      clk_i, rstn_i)
    `D_FLIP_FLOP(r_err,        w_err_nxt,        1'b0,    clk_i, rstn_i)
    `D_FLIP_FLOP(r_req_valid,  w_req_valid_nxt,  1'b0,    clk_i, rstn_i)
    `D_FLIP_FLOP(r_busy,       w_busy_nxt,       1'b0,    clk_i, rstn_i)

    // A flush landing on the write cycle still completes the refill, but empty
    assign w_in_write = (r_state == ST_WRITE);
    assign w_fault    = pte_fault(r_pte, r_err);
    assign w_commit   = w_in_write && !tlb_flush_i && !w_fault;

    itlb_victim_sel #(
        .ENTRY_NUM (ENTRY_NUM)
    ) u_victim_sel (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .entry_valid_i (entry_valid_i),
        .commit_i      (w_commit),
        .victim_oh_o   (w_victim_oh)
    );

    assign ptw_req_valid_o = r_req_valid;
    assign ptw_req_asid_o  = r_asid;
    assign ptw_req_vpn_o   = r_vpn;
    assign entry_we_o      = w_commit ? w_victim_oh : '0;
    assign entry_asid_o    = r_asid;
    assign entry_vpn_o     = r_vpn;
    assign entry_pte_o     = r_pte;
    assign entry_g_o       = r_pte[PTE_G];
    assign busy_o          = r_busy;
    assign refill_done_o   = w_in_write;
    assign refill_fault_o  = w_in_write && !tlb_flush_i && w_fault;

endmodule

`default_nettype wire

// File: tb/tb_itlb_refill_ctrl.sv
`default_nettype none
//==============================================================================
// Module : tb_itlb_refill_ctrl
// Desc   : Randomized refill transactions checked against a transaction model.
// Rev    : 1.0  initial release
//==============================================================================

module tb_itlb_refill_ctrl;
    import mms_pkg::*;

    localparam int ENTRY_NUM = 8;
    localparam int N_RAND    = 150;
    localparam int NONE      = 99;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 tlb_flush = 1'b0;
    logic                 miss = 1'b0;
    logic [8:0]           miss_asid = '0;
    logic [19:0]          miss_vpn = '0;
    logic [ENTRY_NUM-1:0] entry_valid = '0;
    logic                 ptw_req_valid;
    logic                 ptw_req_ready = 1'b0;
    logic [8:0]           ptw_req_asid;
    logic [19:0]          ptw_req_vpn;
    logic                 ptw_resp_valid = 1'b0;
    logic [31:0]          ptw_resp_pte = '0;
    logic                 ptw_resp_err = 1'b0;
    logic [ENTRY_NUM-1:0] entry_we;
    logic [8:0]           entry_asid;
    logic [19:0]          entry_vpn;
    logic [31:0]          entry_pte;
    logic                 entry_g;
    logic                 busy;
    logic                 refill_done;
    logic                 refill_fault;

    itlb_refill_ctrl #(.ENTRY_NUM(ENTRY_NUM)) dut (
        .clk_i            (clk),
        .rstn_i           (rstn),
        .tlb_flush_i      (tlb_flush),
        .miss_i           (miss),
        .miss_asid_i      (miss_asid),
        .miss_vpn_i       (miss_vpn),
        .entry_valid_i    (entry_valid),
        .ptw_req_valid_o  (ptw_req_valid),
        .ptw_req_ready_i  (ptw_req_ready),
        .ptw_req_asid_o   (ptw_req_asid),
        .ptw_req_vpn_o    (ptw_req_vpn),
        .ptw_resp_valid_i (ptw_resp_valid),
        .ptw_resp_pte_i   (ptw_resp_pte),
        .ptw_resp_err_i   (ptw_resp_err),
        .entry_we_o       (entry_we),
        .entry_asid_o     (entry_asid),
        .entry_vpn_o      (entry_vpn),
        .entry_pte_o      (entry_pte),
        .entry_g_o        (entry_g),
        .busy_o           (busy),
        .refill_done_o    (refill_done),
        .refill_fault_o   (refill_fault)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int model_ptr = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rstn = 1'b0; miss = 1'b0; tlb_flush = 1'b0; ptw_req_ready = 1'b0; ptw_resp_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        model_ptr = 0;
        @(negedge clk);
        check_eq("rst_busy",  32'(busy), 32'd0);
        check_eq("rst_req",   32'(ptw_req_valid), 32'd0);
        check_eq("rst_we",    32'(entry_we), 32'd0);
        check_eq("rst_done",  32'(refill_done), 32'd0);
        check_eq("rst_fault", 32'(refill_fault), 32'd0);
        check_eq("rst_pte",   entry_pte, 32'd0);
        check_eq("rst_asid",  32'(entry_asid), 32'd0);
        check_eq("rst_vpn",   32'(entry_vpn), 32'd0);
    endtask

    // One complete miss: rdy_dly stall cycles before accept, resp_dly cycles to response
    task automatic run_refill(input logic [8:0] asid, input logic [19:0] vpn,
                              input int rdy_dly, input int flush_req_k,
                              input int resp_dly, input int flush_wait_t,
                              input logic [31:0] pte, input logic err,
                              input logic [7:0] vmask, input logic flush_w);
        logic            drained;
        logic            fault;
        logic [7:0]      exp_we;
        int              victim;

        @(posedge clk); #1;
        miss = 1'b1; miss_asid = asid; miss_vpn = vpn;
        tlb_flush = 1'b0; ptw_req_ready = 1'b0; ptw_resp_valid = 1'b0;
        @(negedge clk);
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_req",  32'(ptw_req_valid), 32'd0);

        drained = 1'b0;
        for (int k = 0; k <= rdy_dly; k++) begin
            @(posedge clk); #1;
            miss = 1'($urandom_range(0, 1)); miss_asid = 9'($urandom); miss_vpn = 20'($urandom);
            ptw_req_ready = (k == rdy_dly);
            tlb_flush     = (k == flush_req_k);
            entry_valid   = 8'($urandom);
            if (k == flush_req_k) drained = 1'b1;
            @(negedge clk);
            check_eq("req_valid", 32'(ptw_req_valid), 32'd1);
            check_eq("req_asid",  32'(ptw_req_asid), 32'(asid));
            check_eq("req_vpn",   32'(ptw_req_vpn), 32'(vpn));
            check_eq("req_busy",  32'(busy), 32'd1);
        end

        for (int t = 0; t <= resp_dly; t++) begin
            @(posedge clk); #1;
            miss = 1'($urandom_range(0, 1)); miss_asid = 9'($urandom); miss_vpn = 20'($urandom);
            ptw_req_ready  = 1'($urandom_range(0, 1));
            ptw_resp_valid = (t == resp_dly);
            ptw_resp_pte   = (t == resp_dly) ? pte : $urandom;
            ptw_resp_err   = (t == resp_dly) ? err : 1'($urandom_range(0, 1));
            tlb_flush      = (t == flush_wait_t);
            if (t == flush_wait_t) drained = 1'b1;
            @(negedge clk);
            check_eq("wait_req",  32'(ptw_req_valid), 32'd0);
            check_eq("wait_busy", 32'(busy), 32'd1);
            check_eq("wait_we",   32'(entry_we), 32'd0);
            check_eq("wait_done", 32'(refill_done), 32'd0);
        end

        @(posedge clk); #1;
        ptw_resp_valid = 1'b0;
        ptw_req_ready  = 1'b0;
        entry_valid    = vmask;
        if (drained) begin
            miss = 1'b0;
            tlb_flush = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_eq("drain_busy",  32'(busy), 32'd0);
            check_eq("drain_we",    32'(entry_we), 32'd0);
            check_eq("drain_done",  32'(refill_done), 32'd0);
            check_eq("drain_fault", 32'(refill_fault), 32'd0);
        end else begin
            miss = 1'($urandom_range(0, 1));
            tlb_flush = flush_w;
            fault = err | ~pte[0] | ~pte[3] | (pte[2] & ~pte[1]);
            victim = -1;
            for (int i = 0; i < ENTRY_NUM; i++) begin
                if (!vmask[i] && victim < 0) victim = i;
            end
            exp_we = '0;
            if (!flush_w && !fault) begin
                if (victim < 0) begin
                    victim = model_ptr;
                    model_ptr = (model_ptr + 1) % ENTRY_NUM;
                end
                exp_we = 8'(1 << victim);
            end
            @(negedge clk);
            check_eq("wr_we",    32'(entry_we), 32'(exp_we));
            check_eq("wr_done",  32'(refill_done), 32'd1);
            check_eq("wr_fault", 32'(refill_fault), 32'(fault & ~flush_w));
            check_eq("wr_g",     32'(entry_g), 32'(pte[5]));
            check_eq("wr_pte",   entry_pte, pte);
            check_eq("wr_asid",  32'(entry_asid), 32'(asid));
            check_eq("wr_vpn",   32'(entry_vpn), 32'(vpn));
            check_eq("wr_busy",  32'(busy), 32'd1);
            @(posedge clk); #1;
            miss = 1'b0; tlb_flush = 1'b0;
            @(negedge clk);
            check_eq("post_busy", 32'(busy), 32'd0);
            check_eq("post_done", 32'(refill_done), 32'd0);
        end
        @(posedge clk); #1;
        miss = 1'b0; tlb_flush = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy, fk, rsp, fw;
        logic [31:0] pte;

        apply_reset();

        run_refill(9'd2, 20'h004FF, 0, NONE, 0, NONE, 32'h0000_00CB, 1'b0, 8'h00, 1'b0);
        run_refill(9'd5, 20'h12345, 5, 2, 1, NONE, 32'h0000_00CB, 1'b0, 8'h00, 1'b0);

        apply_reset();
        for (int i = 0; i < 9; i++) begin
            run_refill(9'(i), 20'(i * 16), 0, NONE, 1, NONE, 32'h0000_00EB, 1'b0, 8'hFF, 1'b0);
        end
        run_refill(9'd7, 20'h00777, 1, NONE, 0, NONE, 32'h0000_0003, 1'b0, 8'hFF, 1'b0);
        run_refill(9'd8, 20'h00888, 0, NONE, 2, NONE, 32'h0000_00CB, 1'b1, 8'hFF, 1'b0);
        run_refill(9'd9, 20'h00999, 0, NONE, 0, NONE, 32'h0000_00CB, 1'b0, 8'hFF, 1'b1);
        run_refill(9'd10, 20'h00AAA, 0, NONE, 0, NONE, 32'h0000_00CB, 1'b0, 8'hFF, 1'b0);
        run_refill(9'd11, 20'h00BBB, 0, NONE, 3, 3, 32'h0000_00CB, 1'b0, 8'h00, 1'b0);

        // Asynchronous reset while waiting for the walker
        @(posedge clk); #1;
        miss = 1'b1; miss_asid = 9'h1AB; miss_vpn = 20'hABCDE;
        @(posedge clk); #1;
        miss = 1'b0; ptw_req_ready = 1'b1;
        @(posedge clk); #1;
        ptw_req_ready = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_req",  32'(ptw_req_valid), 32'd0);
        check_eq("arst_asid", 32'(entry_asid), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        model_ptr = 0;
        ptw_resp_valid = 1'b1; ptw_resp_pte = 32'h0000_00CB; ptw_resp_err = 1'b0;
        entry_valid = 8'h00;
        @(negedge clk);
        check_eq("arst_resp_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        ptw_resp_valid = 1'b0;
        @(negedge clk);
        check_eq("arst_late_we",   32'(entry_we), 32'd0);
        check_eq("arst_late_done", 32'(refill_done), 32'd0);
        check_eq("arst_late_busy", 32'(busy), 32'd0);

        for (int n = 0; n < N_RAND; n++) begin
            rdy = $urandom_range(0, 4);
            fk  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, rdy) : NONE;
            rsp = $urandom_range(0, 4);
            fw  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, rsp) : NONE;
            pte = $urandom;
            if ($urandom_range(0, 1) == 1) pte = pte | 32'h0000_000B;
            run_refill(9'($urandom), 20'($urandom), rdy, fk, rsp, fw, pte,
                       ($urandom_range(0, 7) == 0),
                       ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom),
                       ($urandom_range(0, 7) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
